// File: rtl/data_bus_pkg.sv
// Shared constants and types for the data-bus responder: region codes, timer register map,
// and CTRL bit positions.
package data_bus_pkg;

   localparam logic [3:0] RAM_REGION = 4'h0;
   localparam logic [3:0] TMR_REGION = 4'h1;

   typedef enum logic [2:0] {
      RegCtrl   = 3'd0,
      RegPsc    = 3'd1,
      RegCnt    = 3'd2,
      RegCmp    = 3'd3,
      RegStatus = 3'd4
   } tmr_reg_e;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_AUTOCLR = 1;
   localparam int unsigned CTRL_IEN     = 2;

endpackage

// File: rtl/data_bus_responder_timer.sv
// Prescaled 32-bit timer with compare match, sticky match flag and level interrupt.
// Register file is word-selected by sel_i; reads are combinational.
module timer_periph
   import data_bus_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [2:0]  sel_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] psc_q, psc_d;
   logic [15:0] psc_cnt_q, psc_cnt_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cmp_q, cmp_d;
   logic        match_q, match_d;

   logic wr_ctrl, wr_psc, wr_cnt, wr_cmp, wr_status;
   logic en, tick, cnt_hit;

   always_comb begin
      wr_ctrl   = we_i && (sel_i == RegCtrl);
      wr_psc    = we_i && (sel_i == RegPsc);
      wr_cnt    = we_i && (sel_i == RegCnt);
      wr_cmp    = we_i && (sel_i == RegCmp);
      wr_status = we_i && (sel_i == RegStatus);
      en        = ctrl_q[CTRL_EN];
      // A PSC write restarts the prescaler and suppresses this cycle's tick.
      tick      = en && !wr_psc && (psc_cnt_q == psc_q);
      cnt_hit   = (cnt_q == cmp_q);

      ctrl_d    = wr_ctrl ? wdata_i[2:0] : ctrl_q;
      psc_d     = wr_psc ? wdata_i[15:0] : psc_q;
      cmp_d     = wr_cmp ? wdata_i : cmp_q;

      psc_cnt_d = psc_cnt_q;
      if (wr_psc) begin
         psc_cnt_d = '0;
      end else if (en) begin
         psc_cnt_d = tick ? '0 : psc_cnt_q + 16'd1;
      end

      cnt_d = cnt_q;
      if (wr_cnt) begin
         cnt_d = wdata_i;
      end else if (tick) begin
         cnt_d = (cnt_hit && ctrl_q[CTRL_AUTOCLR]) ? '0 : cnt_q + 32'd1;
      end

      // Set has priority over write-1-to-clear.
      match_d = match_q;
      if (wr_status && wdata_i[0]) begin
         match_d = 1'b0;
      end
      if (tick && cnt_hit) begin
         match_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ctrl_q    <= '0;
         psc_q     <= '0;
         psc_cnt_q <= '0;
         cnt_q     <= '0;
         cmp_q     <= '0;
         match_q   <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         psc_q     <= psc_d;
         psc_cnt_q <= psc_cnt_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         match_q   <= match_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (sel_i)
         RegCtrl:   rdata_o = {29'd0, ctrl_q};
         RegPsc:    rdata_o = {16'd0, psc_q};
         RegCnt:    rdata_o = cnt_q;
         RegCmp:    rdata_o = cmp_q;
         RegStatus: rdata_o = {31'd0, match_q};
         default:   rdata_o = '0;
      endcase
      irq_o = match_q & ctrl_q[CTRL_IEN];
   end

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: decodes the core's data address into the on-chip RAM and the timer.
// No handshake; reads are combinational and writes land on the next rising edge.
module data_bus_responder
   import data_bus_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dataWe,
   input  logic [31:0] dataAddr,
   input  logic [31:0] dataWData,
   output logic [31:0] dataRData,
   output logic        timerIrq
);

   localparam int unsigned AW = $clog2(RAM_WORDS);

   logic [3:0]    region;
   logic [AW-1:0] ram_idx;
   logic          ram_hit, tmr_hit, tmr_we;
   logic [31:0]   tmr_rdata;
   logic [31:0]   ram_q [RAM_WORDS];
   logic          unused_addr;

   always_comb begin
      region  = dataAddr[31:28];
      ram_idx = dataAddr[AW+1:2];
      ram_hit = (region == RAM_REGION);
      tmr_hit = (region == TMR_REGION);
      tmr_we  = dataWe && tmr_hit;
   end

   // Upper in-region offset bits alias; byte offset is ignored.
   assign unused_addr = ^{dataAddr[27:AW+2], dataAddr[1:0]};

   always_ff @(posedge clk) begin
      if (dataWe && ram_hit) begin
         ram_q[ram_idx] <= dataWData;
      end
   end

   timer_periph u_timer (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (tmr_we),
      .sel_i   (dataAddr[4:2]),
      .wdata_i (dataWData),
      .rdata_o (tmr_rdata),
      .irq_o   (timerIrq)
   );

   always_comb begin
      dataRData = '0;
      case (region)
         RAM_REGION: dataRData = ram_q[ram_idx];
         TMR_REGION: dataRData = tmr_rdata;
         default:    dataRData = '0;
      endcase
   end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder end of the RV32I core's data bus: decodes `dataAddr`, serves word accesses from an on-chip data RAM, and hosts a memory-mapped prescaled timer with compare match and interrupt. Sits beside the core at SoC top level, wired directly to `dataWe`/`dataAddr`/`dataWData`/`dataRData`. The bus has no handshake: reads return combinationally in the same cycle and writes commit on the next rising edge, so the single-cycle core never stalls.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `dataWe` input 1: write strobe from the core.
- `dataAddr` input 32: byte address. Bits [1:0] are ignored; all accesses are full words.
- `dataWData` input 32: write data.
- `dataRData` output 32: read data, combinational from `dataAddr` and current state.
- `timerIrq` output 1: timer interrupt, level, equals `STATUS.match & CTRL.ien`.

## Operation
- Decode on `dataAddr[31:28]`:
  - 0x0: RAM.
  - 0x1: timer.
  - any other value: unmapped; reads return 0, writes are ignored.
- RAM:
  - Word index `dataAddr[log2(RAM_WORDS)+1:2]`; higher offset bits in the region alias.
  - Write when `dataWe` and RAM hit. Combinational read.
  - Contents are not reset.
- Timer registers, selected by `dataAddr[4:2]`:
  - 0x00 CTRL: bit0 `en`, bit1 `autoclr`, bit2 `ien`; other bits read 0.
  - 0x04 PSC: [15:0] prescale value; upper bits read 0.
  - 0x08 CNT: 32-bit counter.
  - 0x0C CMP: 32-bit compare value.
  - 0x10 STATUS: bit0 `match`; writing 1 to bit0 clears it, writing 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- Prescaler:
  - Internal `psc_cnt` (16 bit) runs only while `en`=1.
  - When `psc_cnt==PSC`, `psc_cnt` returns to 0 and a one-cycle `tick` is produced; otherwise `psc_cnt` increments.
  - PSC=0 gives a tick every cycle.
- On `tick`:
  - If `CNT==CMP`: set `match`; `CNT` becomes 0 when `autoclr`=1, else `CNT+1`.
  - Otherwise `CNT` becomes `CNT+1`.
  - Increment wraps modulo 2^32 (0xFFFF_FFFF → 0).
- Clearing `en` freezes both `psc_cnt` and `CNT`. Setting it again resumes from the frozen values.
- Simultaneous events:
  - Bus write to CNT and a tick in the same cycle: the written value wins, and no increment is applied.
  - Bus write to PSC: `psc_cnt` resets to 0 in the same edge; no tick that cycle.
  - Write-1-to-clear of `match` and a new match in the same cycle: set wins, `match`=1.
  - Bus write to CMP and a tick in the same cycle: the tick compares against the old CMP.
- Reset: CTRL, PSC, CNT, CMP, `psc_cnt`, and `match` all become 0, so `timerIrq`=0. Reset mid-count abandons the count. Reset dominates any simultaneous bus write.

## Timing
- Read latency 0: `dataRData` is valid in the same cycle as `dataAddr`. A read of CNT returns the pre-edge value.
- Write latency 1: the value is visible to a read in the cycle after the write.
- `match` and `timerIrq` rise in the cycle after the matching tick edge.
- Tick period is PSC+1 cycles. With CMP=N, `autoclr`=1 and CNT starting at 0, match-to-match spacing is (N+1)·(PSC+1) cycles.
- `dataRData` during reset follows current register state: 0 for timer registers once the reset edge has occurred.

## Structure
- Package `data_bus_pkg`:
  - Region codes (`RAM_REGION`=4'h0, `TMR_REGION`=4'h1).
  - Timer register offset enum (CTRL, PSC, CNT, CMP, STATUS).
  - CTRL bit index constants.
- Sub-module `timer_periph`: owns prescaler, CNT, CMP, CTRL, STATUS and the irq logic. Takes write enable, 3-bit register select and wdata; returns rdata.
- Top level holds the address decode, RAM array and read mux.

## Test plan
- **RAM round trip:** write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0013 → same word. Read 0x0000_0110 with RAM_WORDS=64 → aliases to the same word.
- **Unmapped region:** write 0x1234 to 0x2000_0000 → a RAM read at 0x0 is unchanged. Read 0x2000_0000 → 0.
- **Prescaled count:** PSC=3, CMP=2, CTRL=0b111 → `match`/`timerIrq` rise 12 cycles after enable, CNT returns to 0. W1C to STATUS drops `timerIrq` next cycle.
- **Wrap and freeze:** CNT=0xFFFF_FFFE, PSC=0, en=1 → CNT reads 0xFFFF_FFFF then 0. Clearing `en` holds CNT steady for 10 cycles.
- **Collisions:** CNT write coincident with tick → written value exact. W1C coincident with match → `match` stays 1.
- **Reset mid-run:** assert `reset`=0 for one edge while counting with `timerIrq`=1 → all timer registers read 0 and `timerIrq`=0; RAM contents retained.
